// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and encodings for the register-file sequencer/arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_ctrl_pkg;

  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DW_DEF    = 32;

  // r0 is hardwired to zero from the pipeline's point of view.
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_ctrl_fwd.sv
// Per-read-port forwarding and hold logic for the register file.
// Latency: result one cycle after capture, held until the next capture.
// Backpressure: none; capture is driven by the pipeline advance strobe.
module regfile_fwd
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          cap_en,
  input  logic          rd_en_d,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_gnt,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rf_q,
  output logic [DW-1:0] q
);

  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic          fwd_q, fwd_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] q_int;

  // Select the visible result and compute capture, forward and hold updates.
  always_comb begin
    cap_addr_d = cap_addr_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    hold_d     = hold_q;

    // Fresh read cycle shows RAM data (or the forwarded write); otherwise the held copy,
    // since write-only enable pulses may clobber the RAM output register.
    q_int = rd_en_d ? (fwd_q ? fwd_data_q : rf_q) : hold_q;

    if (cap_en) begin
      cap_addr_d = rd_addr;
      // The RAM returns old data on write-during-read, so remember the new value.
      fwd_d      = wr_gnt && (wr_addr == rd_addr);
      fwd_data_d = wr_data;
    end

    if (rd_en_d) begin
      hold_d = q_int;
    end

    // A later write to the delivered address must be reflected while stalled;
    // it is newer than whatever the RAM produced, so it takes precedence.
    if (wr_gnt && (wr_addr == cap_addr_q) && (cap_addr_q != AW'(ZERO_REG))) begin
      hold_d = wr_data;
    end
  end

  assign q = q_int;

  // Per-port capture/forward/hold state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr_q <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= '0;
    end else begin
      cap_addr_q <= cap_addr_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Clears the 32x32 register file after reset, then arbitrates its write port and wraps its read ports.
// Latency: writes go out combinationally; reads return one cycle after capture, held across stalls.
// Backpressure: writeback port never stalls; load unit stalls (b_ready=0) when writeback takes the port or during the clear sweep.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic          a_wren,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          init_busy,
  output logic          rf_enable,
  output logic [AW-1:0] rf_rdaddress_a,
  output logic [AW-1:0] rf_rdaddress_b,
  output logic          rf_wren,
  output logic [AW-1:0] rf_wraddress,
  output logic [DW-1:0] rf_data,
  input  logic [DW-1:0] rf_qa,
  input  logic [DW-1:0] rf_qb
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rd_en_d_q, rd_en_d_d;

  logic          in_init;
  logic          in_run;
  logic          a_hit;
  logic          b_hit;
  logic          a_gnt;
  logic          b_gnt;
  logic          wr_gnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_cap;

  assign in_init = (state_q == ST_INIT);
  assign in_run  = (state_q == ST_RUN);

  // Write-port arbitration: writeback first, r0 writes are dropped without blocking the load unit.
  always_comb begin
    a_hit   = a_wren  && (a_addr != AW'(ZERO_REG));
    b_hit   = b_valid && (b_addr != AW'(ZERO_REG));
    a_gnt   = in_run && a_hit;
    b_gnt   = in_run && !a_hit && b_hit;
    wr_gnt  = a_gnt || b_gnt;
    wr_addr = a_gnt ? a_addr : b_addr;
    wr_data = a_gnt ? a_data : b_data;
    // A load to r0 still completes its handshake; only the RAM write is suppressed.
    b_ready = in_run && !a_hit;
    // Reads are only meaningful once the file has been cleared.
    rd_cap  = in_run && rd_en;
  end

  // Drive the register-file port: the clear sweep owns the write port during INIT.
  always_comb begin
    rf_rdaddress_a = rd_addr_a;
    rf_rdaddress_b = rd_addr_b;
    rf_enable      = in_init || rd_en || wr_gnt;
    if (in_init) begin
      rf_wren      = 1'b1;
      rf_wraddress = cnt_q;
      rf_data      = '0;
    end else begin
      rf_wren      = wr_gnt;
      rf_wraddress = wr_addr;
      rf_data      = wr_data;
    end
  end

  // Sequencer next state: sweep every register once, then run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en_d_d = rd_cap;
    if (in_init) begin
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // Sequencer and read-pipeline state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rd_en_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_en_d_q <= rd_en_d_d;
    end
  end

  assign init_busy = in_init;

  regfile_fwd #(.AW(AW), .DW(DW)) u_fwd_a (
    .clock   (clock),
    .rst_n   (rst_n),
    .cap_en  (rd_cap),
    .rd_en_d (rd_en_d_q),
    .rd_addr (rd_addr_a),
    .wr_gnt  (wr_gnt),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rf_q    (rf_qa),
    .q       (qa)
  );

  regfile_fwd #(.AW(AW), .DW(DW)) u_fwd_b (
    .clock   (clock),
    .rst_n   (rst_n),
    .cap_en  (rd_cap),
    .rd_en_d (rd_en_d_q),
    .rd_addr (rd_addr_b),
    .wr_gnt  (wr_gnt),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rf_q    (rf_qb),
    .q       (qb)
  );

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 32x32 RAM and a read scoreboard.
// Latency: reads checked one cycle after capture.
// Backpressure: load-unit handshake checked against the writeback priority rule.
module tb_regfile_ctrl;

  logic        clock;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] qa, qb;
  logic        a_wren;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        init_busy;
  logic        rf_enable;
  logic [4:0]  rf_rdaddress_a, rf_rdaddress_b;
  logic        rf_wren;
  logic [4:0]  rf_wraddress;
  logic [31:0] rf_data;
  logic [31:0] rf_qa, rf_qb;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] ref_mem[32];
  logic [31:0] ram[32];

  regfile_ctrl dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .rd_en          (rd_en),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .qa             (qa),
    .qb             (qb),
    .a_wren         (a_wren),
    .a_addr         (a_addr),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_addr         (b_addr),
    .b_data         (b_data),
    .b_ready        (b_ready),
    .init_busy      (init_busy),
    .rf_enable      (rf_enable),
    .rf_rdaddress_a (rf_rdaddress_a),
    .rf_rdaddress_b (rf_rdaddress_b),
    .rf_wren        (rf_wren),
    .rf_wraddress   (rf_wraddress),
    .rf_data        (rf_data),
    .rf_qa          (rf_qa),
    .rf_qb          (rf_qb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: common enable, registered reads returning old data on write-during-read.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = $urandom | 32'h1;
    rf_qa = 32'h0;
    rf_qb = 32'h0;
  end

  always @(posedge clock) begin
    if (rf_enable) begin
      if (rf_wren) ram[rf_wraddress] <= rf_data;
      rf_qa <= ram[rf_rdaddress_a];
      rf_qb <= ram[rf_rdaddress_b];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic rd_issue(input logic [4:0] a, input logic [4:0] b);
    rd_exp_t e;
    rd_en     = 1'b1;
    rd_addr_a = a;
    rd_addr_b = b;
    e.a = ref_mem[a];
    e.b = ref_mem[b];
    sb.push_back(e);
  endtask

  task automatic rd_check(input string tag);
    rd_exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: observed=empty required=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_qa"}, qa, e.a);
      chk({tag, "_qb"}, qb, e.b);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b, input string tag);
    rd_issue(a, b);
    nxt();
    rd_en = 1'b0;
    #1;
    rd_check(tag);
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk({tag, "_wren"}, {31'b0, rf_wren}, 32'h1);
      chk({tag, "_waddr"}, {27'b0, rf_wraddress}, 32'(i));
      chk({tag, "_wdata"}, rf_data, 32'h0);
      chk({tag, "_busy"}, {31'b0, init_busy}, 32'h1);
      chk({tag, "_bready"}, {31'b0, b_ready}, 32'h0);
      nxt();
    end
    #1;
    chk({tag, "_done"}, {31'b0, init_busy}, 32'h0);
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    a_wren = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h0000_BEEF;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    // Reset state.
    nxt(); nxt();
    #1;
    chk("rst_qa", qa, 32'h0);
    chk("rst_qb", qb, 32'h0);
    chk("rst_busy", {31'b0, init_busy}, 32'h1);
    chk("rst_bready", {31'b0, b_ready}, 32'h0);

    // Clear sweep, with B already waiting.
    nxt();
    rst_n = 1'b1;
    sweep_check("sweep");

    // A writes r5 while B waits with r6.
    a_wren = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
    #1;
    chk("prio_bready", {31'b0, b_ready}, 32'h0);
    chk("prio_waddr", {27'b0, rf_wraddress}, 32'd5);
    chk("prio_wdata", rf_data, 32'h0000_1234);
    ref_mem[5] = 32'h0000_1234;
    nxt();
    a_wren = 1'b0;
    #1;
    chk("bwin_bready", {31'b0, b_ready}, 32'h1);
    chk("bwin_wren", {31'b0, rf_wren}, 32'h1);
    chk("bwin_waddr", {27'b0, rf_wraddress}, 32'd6);
    ref_mem[6] = 32'h0000_BEEF;
    nxt();
    b_valid = 1'b0;
    do_read(5'd5, 5'd6, "rd56");
    do_read(5'd0, 5'd31, "rd0_31");
    do_read(5'd12, 5'd20, "rd12_20");

    // Write-during-read forwarding on port A.
    nxt();
    a_wren = 1'b1; a_addr = 5'd7; a_data = 32'h0000_CAFE;
    ref_mem[7] = 32'h0000_CAFE;
    rd_issue(5'd7, 5'd5);
    nxt();
    a_wren = 1'b0; rd_en = 1'b0;
    #1;
    rd_check("fwd7");

    // Seed r10 and r3, then capture r9/r10 and stall while writes hit the RAM.
    nxt();
    a_wren = 1'b1; a_addr = 5'd10; a_data = 32'h0000_0A10; ref_mem[10] = 32'h0000_0A10;
    nxt();
    a_addr = 5'd3; a_data = 32'h0000_0333; ref_mem[3] = 32'h0000_0333;
    nxt();
    a_wren = 1'b0;
    do_read(5'd9, 5'd10, "cap9_10");
    rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    nxt();
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h0000_0033; ref_mem[3] = 32'h0000_0033;
    #1;
    chk("hold1_bready", {31'b0, b_ready}, 32'h1);
    nxt();
    #1;
    chk("hold1_qa", qa, ref_mem[9]);
    chk("hold1_qb", qb, ref_mem[10]);
    b_addr = 5'd9; b_data = 32'h0000_0055; ref_mem[9] = 32'h0000_0055;
    nxt();
    b_valid = 1'b0;
    #1;
    chk("hold2_qa", qa, ref_mem[9]);
    chk("hold2_qb", qb, ref_mem[10]);
    a_wren = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0077; ref_mem[3] = 32'h0000_0077;
    nxt();
    a_wren = 1'b0;
    #1;
    chk("hold3_qa", qa, ref_mem[9]);
    chk("hold3_qb", qb, ref_mem[10]);
    nxt();
    #1;
    chk("hold4_qa", qa, ref_mem[9]);
    chk("hold4_qb", qb, ref_mem[10]);
    do_read(5'd3, 5'd9, "rd3_9");

    // r0 is never written by either source.
    nxt();
    a_wren = 1'b1; a_addr = 5'd0; a_data = 32'h0000_FFFF;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1111;
    #1;
    chk("r0_wren", {31'b0, rf_wren}, 32'h0);
    chk("r0_bready", {31'b0, b_ready}, 32'h1);
    nxt();
    // A dropped r0 write does not block B.
    b_addr = 5'd11; b_data = 32'h0000_0B11;
    #1;
    chk("r0a_bready", {31'b0, b_ready}, 32'h1);
    chk("r0a_wren", {31'b0, rf_wren}, 32'h1);
    chk("r0a_waddr", {27'b0, rf_wraddress}, 32'd11);
    ref_mem[11] = 32'h0000_0B11;
    nxt();
    a_wren = 1'b0; b_valid = 1'b0;
    do_read(5'd0, 5'd11, "rd0_11");

    // Reset mid-run, then again mid-sweep at count 12, with B pending.
    nxt();
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_0444;
    rst_n = 1'b0;
    #1;
    chk("rrun_busy", {31'b0, init_busy}, 32'h1);
    chk("rrun_qa", qa, 32'h0);
    chk("rrun_bready", {31'b0, b_ready}, 32'h0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("part_waddr", {27'b0, rf_wraddress}, 32'(i));
      nxt();
    end
    rst_n = 1'b0;
    #1;
    chk("rsw_waddr", {27'b0, rf_wraddress}, 32'd0);
    chk("rsw_busy", {31'b0, init_busy}, 32'h1);
    nxt();
    rst_n = 1'b1;
    sweep_check("resweep");
    ref_mem[4] = 32'h0000_0444;
    #1;
    chk("post_bready", {31'b0, b_ready}, 32'h1);
    nxt();
    b_valid = 1'b0;
    do_read(5'd5, 5'd4, "rd5_4");
    do_read(5'd11, 5'd7, "rd11_7");

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer and write-port arbiter for the 32x32 register file. The register file has two registered read ports, one write port and a common enable.
- After reset, sweeps all 32 registers to zero, since an initial block does not survive synthesis.
- Then shares the single write port between the pipeline writeback (priority) and the load/long-latency unit (valid/ready).
- Forwards same-cycle write data into read results and holds read data stable across pipeline stalls.

Parameters:
- NREGS, 32, number of registers swept at init (power of two, 2..32).
- AW, 5, register address width, log2(NREGS).
- DW, 32, data width.

Ports:
- clock  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  pipeline advancing; capture rd_addr_a/b this cycle.
- rd_addr_a  in  AW  read address A.
- rd_addr_b  in  AW  read address B.
- qa  out  DW  read result A, one cycle after capture, held until next capture.
- qb  out  DW  read result B, same timing as qa.
- a_wren  in  1  pipeline writeback strobe, no backpressure.
- a_addr  in  AW  pipeline writeback address.
- a_data  in  DW  pipeline writeback data.
- b_valid  in  1  load-unit write request.
- b_addr  in  AW  load-unit write address.
- b_data  in  DW  load-unit write data.
- b_ready  out  1  load-unit request accepted this cycle.
- init_busy  out  1  clear sweep in progress.
- rf_enable  out  1  register file enable.
- rf_rdaddress_a  out  AW  register file read address A.
- rf_rdaddress_b  out  AW  register file read address B.
- rf_wren  out  1  register file write strobe.
- rf_wraddress  out  AW  register file write address.
- rf_data  out  DW  register file write data.
- rf_qa  in  DW  register file read data A (registered, one cycle delayed).
- rf_qb  in  DW  register file read data B (registered, one cycle delayed).

Behaviour:
- Clock/reset (already decided): one clock, named clock; reset rst_n is asynchronous and active-low.
- Reset values: state=INIT, sweep cnt=0, hold_a=hold_b=0, rd_en_d=0, fwd flags=0. So qa=qb=0, init_busy=1, b_ready=0.
- rf_* outputs are combinational from state and inputs. Writing 0 to r0 while in reset is harmless.
- INIT state:
  - rf_wren=1, rf_wraddress=cnt, rf_data=0, rf_enable=1; cnt increments each cycle.
  - After the cnt=NREGS-1 write, go to RUN. The sweep lasts exactly NREGS cycles.
  - b_ready=0 throughout. a_wren and rd_en are ignored; upstream must stall while init_busy=1.
- RUN state, write grant:
  - A is granted when a_wren=1 and a_addr!=0.
  - Otherwise B is granted when b_valid=1 and b_addr!=0.
  - b_ready = RUN and not(a_wren and a_addr!=0).
  - A B handshake with b_addr=0 completes (b_ready=1) but rf_wren=0; r0 is never written.
  - A write to r0 from A is dropped and does not block B.
- rf_enable = INIT or rd_en or write granted. rf_rdaddress_a/b track rd_addr_a/b directly.
- Read/forward:
  - rd_en_d is rd_en registered.
  - If rd_en=1 and a granted write address equals rd_addr_a (b), set fwd_a (fwd_b) and register the write data. The register file returns old data for write-during-read.
  - Cycle after capture (rd_en_d=1): qa = fwd_a ? fwd data : rf_qa; same for qb. That value is loaded into hold_a/hold_b.
  - While rd_en_d=0: qa=hold_a, qb=hold_b. Needed because rf_enable may pulse for writes and overwrite rf_qa/rf_qb.
- Hold coherence: a granted write whose address equals the last captured address updates the matching hold register next cycle. Captured address 0 never updates.
- Simultaneous A and B: A wins; B waits with b_valid held and its data stable.
- Reset mid-sweep or mid-run: immediate return to INIT with cnt=0; the full sweep restarts. An in-flight B request is not acknowledged.

Decomposition:
- Shared package: AW/DW constants, state encoding (INIT, RUN), and the zero-register address constant.
- One natural sub-module: regfile_fwd. It holds the per-port forward/hold logic and is instantiated twice, for A and B.
- The arbiter and init sequencer stay in the top.

Test Plan:
- Release rst_n: rf_wren=1 for exactly 32 cycles with addresses 0..31 and data 0; init_busy falls the cycle after address 31; all qa/qb reads then return 0.
- RUN, A writes r5=0x1234 while B is valid with r6=0xBEEF: b_ready=0 and rf_wraddress=5. Next cycle b_ready=1 and r6 is written; reads of r5/r6 return 0x1234/0xBEEF.
- rd_en with rd_addr_a=7 in the same cycle A writes r7=0xCAFE: qa=0xCAFE next cycle, not the old 0.
- Capture r9 and r10, then deassert rd_en for 4 cycles while B writes r3 and r9=0x55: qa tracks r9 (0x55 after the write), qb stays constant, and r3 traffic never disturbs qa/qb.
- A write to r0=0xFFFF together with B valid to r0: rf_wren=0, b_ready=1, and a read of r0 returns 0.
- Assert rst_n low at sweep cnt=12, release: the sweep restarts at address 0 and runs a full 32 cycles.
